stdp_update_sched: RTL and testbench

Event scheduler that shares one weight-update datapath among `N_SYN` synapses converging on a single post-synaptic neuron. It timestamps every pre- and post-synaptic spike and turns each qualifying spike pairing into a pending update with a captured time difference. Pending updates are issued one at a time, round-robin, over a valid/ready port to the shared `stdp` weight-update engine, so synapses never need their own update logic.

---
 rtl/stdp_pkg.sv | 19 +
 rtl/stdp_rr_arbiter.sv | 30 +++
 rtl/stdp_update_sched.sv | 175 +++++++++++++++++
 tb/tb_stdp_update_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared types and default constants for the STDP update scheduler.
package stdp_pkg;

   localparam int DEF_TW  = 8;
   localparam int DEF_WIN = 32;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } sched_state_e;

   // Request as seen by the shared weight-update engine (default-width build).
   typedef struct packed {
      logic [7:0]        syn;
      logic [DEF_TW-1:0] dt;
      logic              ltp;
   } upd_req_t;

endpackage

// File: rtl/stdp_rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requesting index at or
// above ptr_i, wrapping around to index 0.
module stdp_rr_arbiter #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_oh_o,
   output logic [IW-1:0] gnt_idx_o,
   output logic          gnt_valid_o
);

   always_comb begin
      int j;
      j           = 0;
      gnt_oh_o    = '0;
      gnt_idx_o   = '0;
      gnt_valid_o = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr_i) + k) % N;
         if (!gnt_valid_o && req_i[j]) begin
            gnt_valid_o = 1'b1;
            gnt_oh_o[j] = 1'b1;
            gnt_idx_o   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/stdp_update_sched.sv
// STDP pairing scheduler: timestamps spikes, queues per-synapse updates and
// issues them round-robin to one shared engine. STDP_SCHED_LTD_EN adds LTD.
module stdp_update_sched
   import stdp_pkg::*;
#(
   parameter int N_SYN = 4,
   parameter int TW    = DEF_TW,
   parameter int WIN   = DEF_WIN,
   localparam int SW   = $clog2(N_SYN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SYN-1:0] pre_spike,
   input  logic             post_spike,
   output logic             upd_valid,
   output logic [SW-1:0]    upd_syn,
   output logic [TW-1:0]    upd_dt,
   output logic             upd_ltp,
   input  logic             upd_ready,
   output logic [N_SYN-1:0] pending,
   output logic             busy
);

   localparam logic [TW-1:0] T_MAX = {TW{1'b1}};
   localparam logic [TW-1:0] T_WIN = TW'(WIN);

   // Timers read the number of cycles elapsed since the last spike, so a
   // spike loads 1 and the pairing partner reads the true spike distance.
   logic [TW-1:0]    pre_t_q [N_SYN];
   logic [N_SYN-1:0] ltp_pend_q, ltp_pend_d, ltp_hit, ltp_clr;
   logic [TW-1:0]    ltp_dt_q [N_SYN];
   logic [TW-1:0]    ltp_cap_dt [N_SYN];

   sched_state_e     state_q, state_d;
   logic [SW-1:0]    rr_ptr_q, rr_ptr_d, syn_q, syn_d;
   logic [TW-1:0]    dt_q, dt_d;
   logic [N_SYN-1:0] gnt_oh_q, gnt_oh_d;
   logic [N_SYN-1:0] arb_oh;
   logic [SW-1:0]    arb_idx;
   logic             arb_valid;
   logic             accept;

   assign accept = (state_q == ST_ISSUE) && upd_ready;

   genvar gi;
   generate
      for (gi = 0; gi < N_SYN; gi++) begin : g_ltp_cap
         // A pre spike coincident with the post spike pairs at dt = 0.
         assign ltp_hit[gi]    = post_spike && (pre_spike[gi] || (pre_t_q[gi] < T_WIN));
         assign ltp_cap_dt[gi] = pre_spike[gi] ? '0 : pre_t_q[gi];
      end
   endgenerate

   assign ltp_clr    = (accept && upd_ltp) ? gnt_oh_q : '0;
   assign ltp_pend_d = (ltp_pend_q & ~ltp_clr) | ltp_hit;

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_SYN; i++) begin
         if (reset)
            pre_t_q[i] <= T_MAX;
         else if (pre_spike[i])
            pre_t_q[i] <= TW'(1);
         else if (pre_t_q[i] != T_MAX)
            pre_t_q[i] <= pre_t_q[i] + TW'(1);
      end
      ltp_pend_q <= reset ? '0 : ltp_pend_d;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_SYN; i++)
         if (ltp_hit[i]) ltp_dt_q[i] <= ltp_cap_dt[i];
   end

`ifdef STDP_SCHED_LTD_EN
   logic [TW-1:0]    post_t_q;
   logic [N_SYN-1:0] ltd_pend_q, ltd_pend_d, ltd_hit, ltd_clr;
   logic [TW-1:0]    ltd_dt_q [N_SYN];
   logic             ltp_q, ltp_d;

   generate
      for (gi = 0; gi < N_SYN; gi++) begin : g_ltd_cap
         assign ltd_hit[gi] = pre_spike[gi] && !post_spike && (post_t_q < T_WIN);
      end
   endgenerate

   assign ltd_clr    = (accept && !ltp_q) ? gnt_oh_q : '0;
   assign ltd_pend_d = (ltd_pend_q & ~ltd_clr) | ltd_hit;

   always_ff @(posedge clk) begin
      if (reset)
         post_t_q <= T_MAX;
      else if (post_spike)
         post_t_q <= TW'(1);
      else if (post_t_q != T_MAX)
         post_t_q <= post_t_q + TW'(1);
      ltd_pend_q <= reset ? '0 : ltd_pend_d;
      ltp_q      <= reset ? 1'b0 : ltp_d;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_SYN; i++)
         if (ltd_hit[i]) ltd_dt_q[i] <= post_t_q;
   end

   assign pending = ltp_pend_q | ltd_pend_q;
   assign upd_ltp = ltp_q;
`else
   assign pending = ltp_pend_q;
   assign upd_ltp = 1'b1;
`endif

   stdp_rr_arbiter #(.N(N_SYN)) u_arb (
      .req_i       (pending),
      .ptr_i       (rr_ptr_q),
      .gnt_oh_o    (arb_oh),
      .gnt_idx_o   (arb_idx),
      .gnt_valid_o (arb_valid)
   );

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      syn_d    = syn_q;
      dt_d     = dt_q;
      gnt_oh_d = gnt_oh_q;
`ifdef STDP_SCHED_LTD_EN
      ltp_d    = ltp_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               syn_d    = arb_idx;
               gnt_oh_d = arb_oh;
`ifdef STDP_SCHED_LTD_EN
               // LTP wins when both kinds are pending on the granted synapse.
               ltp_d    = ltp_pend_q[arb_idx];
               dt_d     = ltp_pend_q[arb_idx] ? ltp_dt_q[arb_idx] : ltd_dt_q[arb_idx];
`else
               dt_d     = ltp_dt_q[arb_idx];
`endif
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (upd_ready) begin
               rr_ptr_d = (syn_q == SW'(N_SYN - 1)) ? '0 : syn_q + SW'(1);
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         syn_q    <= '0;
         dt_q     <= '0;
         gnt_oh_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         syn_q    <= syn_d;
         dt_q     <= dt_d;
         gnt_oh_q <= gnt_oh_d;
      end
   end

   assign upd_valid = (state_q == ST_ISSUE);
   assign upd_syn   = syn_q;
   assign upd_dt    = dt_q;
   assign busy      = (|pending) || upd_valid;

endmodule

// File: tb/tb_stdp_update_sched.sv
// Scoreboard bench for stdp_update_sched; expected requests are queued with
// the stimulus and compared as the scheduler issues them.
module tb_stdp_update_sched;

   localparam int N   = 4;
   localparam int TW  = 8;
   localparam int WIN = 32;
`ifdef STDP_SCHED_LTD_EN
   localparam logic LTP_RST = 1'b0;
`else
   localparam logic LTP_RST = 1'b1;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  pre_spike;
   logic          post_spike;
   logic          upd_valid;
   logic [1:0]    upd_syn;
   logic [TW-1:0] upd_dt;
   logic          upd_ltp;
   logic          upd_ready;
   logic [N-1:0]  pending;
   logic          busy;

   always #5 clk = ~clk;

   stdp_update_sched #(.N_SYN(N), .TW(TW), .WIN(WIN)) dut (
      .clk        (clk),
      .reset      (reset),
      .pre_spike  (pre_spike),
      .post_spike (post_spike),
      .upd_valid  (upd_valid),
      .upd_syn    (upd_syn),
      .upd_dt     (upd_dt),
      .upd_ltp    (upd_ltp),
      .upd_ready  (upd_ready),
      .pending    (pending),
      .busy       (busy)
   );

   typedef struct packed {
      logic [1:0]    syn;
      logic [TW-1:0] dt;
      logic          ltp;
   } exp_t;

   exp_t exp_q[$];
   int   acc_cyc[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   // Monitor: hold-stability while stalled, scoreboard compare on accept.
   logic          prev_v = 1'b0;
   logic          prev_r = 1'b0;
   logic [1:0]    prev_syn;
   logic [TW-1:0] prev_dt;
   logic          prev_ltp;

   always @(negedge clk) begin
      if (reset) begin
         prev_v <= 1'b0;
      end else begin
         if (prev_v && !prev_r) begin
            chk("hold_valid", upd_valid, 1);
            chk("hold_syn", upd_syn, prev_syn);
            chk("hold_dt", upd_dt, prev_dt);
            chk("hold_ltp", upd_ltp, prev_ltp);
         end
         if (upd_valid && upd_ready) begin
            exp_t e;
            acc_cyc.push_back(cyc);
            $display("REQ cyc=%0d syn=%0d dt=%0d ltp=%0d", cyc, upd_syn, upd_dt, upd_ltp);
            if (exp_q.size() == 0) begin
               chk("unexpected_req", upd_valid, 0);
            end else begin
               e = exp_q.pop_front();
               chk("req_syn", upd_syn, e.syn);
               chk("req_dt", upd_dt, e.dt);
               chk("req_ltp", upd_ltp, e.ltp);
            end
         end
         prev_v   <= upd_valid;
         prev_r   <= upd_ready;
         prev_syn <= upd_syn;
         prev_dt  <= upd_dt;
         prev_ltp <= upd_ltp;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic spike(input logic [N-1:0] pre, input logic post);
      pre_spike  = pre;
      post_spike = post;
      tick();
      pre_spike  = '0;
      post_spike = 1'b0;
   endtask

   task automatic push(input int syn, input int dt, input logic ltp);
      exp_t e;
      e.syn = 2'(syn);
      e.dt  = TW'(dt);
      e.ltp = ltp;
      exp_q.push_back(e);
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while ((exp_q.size() != 0 || busy) && k < 200) begin
         tick();
         k++;
      end
      chk(tag, exp_q.size(), 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, upd_valid, 0);
      chk({tag, "_syn"}, upd_syn, 0);
      chk({tag, "_dt"}, upd_dt, 0);
      chk({tag, "_ltp"}, upd_ltp, LTP_RST);
      chk({tag, "_pending"}, pending, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      reset      = 1'b1;
      pre_spike  = '0;
      post_spike = 1'b0;
      upd_ready  = 1'b1;
      idle(3);
      chk_reset_outputs("rst");
      reset = 1'b0;

      // Basic pairing: pre then post 5 cycles later.
      idle(5);
      spike(4'b0100, 1'b0);
      idle(4);
      push(2, 5, 1'b1);
      spike('0, 1'b1);
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (upd_valid && lat == 0) lat = k;
      end
      chk("pair_latency", lat, 2);
      tick();
      drain("pair_drain");

      // Exactly WIN apart is outside the window.
      idle(40);
      spike(4'b0001, 1'b0);
      idle(WIN - 1);
      spike('0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("oow_busy", busy, 0);
      end

      // WIN-1 apart is the last qualifying distance.
      idle(40);
      spike(4'b0001, 1'b0);
      idle(WIN - 2);
      push(0, WIN - 1, 1'b1);
      spike('0, 1'b1);
      drain("edge_drain");

      // Fan-out from rr_ptr = 0.
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(5);
      acc_cyc.delete();
      for (int s = 0; s < N; s++) push(s, 3, 1'b1);
      spike(4'b1111, 1'b0);
      idle(2);
      spike('0, 1'b1);
      drain("fan1_drain");
      chk("fan1_count", acc_cyc.size(), 4);
      for (int i = 1; i < acc_cyc.size(); i++)
         chk("fan1_gap", acc_cyc[i] - acc_cyc[i-1], 2);

      // Coincident pre/post on syn0 moves rr_ptr to 1.
      idle(40);
      push(0, 0, 1'b1);
      spike(4'b0001, 1'b1);
      drain("single_drain");

      idle(40);
      acc_cyc.delete();
      push(1, 3, 1'b1);
      push(2, 3, 1'b1);
      push(3, 3, 1'b1);
      push(0, 3, 1'b1);
      spike(4'b1111, 1'b0);
      idle(2);
      spike('0, 1'b1);
      drain("fan2_drain");
      chk("fan2_count", acc_cyc.size(), 4);
      for (int i = 1; i < acc_cyc.size(); i++)
         chk("fan2_gap", acc_cyc[i] - acc_cyc[i-1], 2);

      // Backpressure with a re-trigger of the non-granted synapse.
      idle(40);
      upd_ready = 1'b0;
      spike(4'b0110, 1'b0);
      idle(1);
      spike('0, 1'b1);
      idle(3);
      chk("bp_pending", pending, 4'b0110);
      chk("bp_valid", upd_valid, 1);
      chk("bp_syn", upd_syn, 1);
      idle(WIN + 5);
      spike(4'b0100, 1'b0);
      idle(4);
      spike('0, 1'b1);
      idle(2);
      chk("bp_syn_hold", upd_syn, 1);
      chk("bp_dt_hold", upd_dt, 2);
      push(1, 2, 1'b1);
      push(2, 5, 1'b1);
      upd_ready = 1'b1;
      drain("bp_drain");

      // Coincident pre1+post: LTP dt=0 only; later pre3 pairs as LTD.
      idle(40);
      spike('0, 1'b1);
      idle(3);
      push(1, 0, 1'b1);
      spike(4'b0010, 1'b1);
      idle(1);
`ifdef STDP_SCHED_LTD_EN
      push(3, 2, 1'b0);
`endif
      spike(4'b1000, 1'b0);
      drain("sim_drain");

      // Reset while a request is outstanding and three synapses are pending.
      idle(40);
      upd_ready = 1'b0;
      spike(4'b0111, 1'b0);
      idle(1);
      spike('0, 1'b1);
      idle(3);
      chk("mid_valid", upd_valid, 1);
      chk("mid_pending", pending, 4'b0111);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      chk_reset_outputs("midrst");
      upd_ready = 1'b1;
      idle(10);
      chk("post_rst_busy", busy, 0);
      push(3, 1, 1'b1);
      spike(4'b1000, 1'b0);
      spike('0, 1'b1);
      drain("recover_drain");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
